// File: rtl/freq_div_ctrl_if.sv
// -----------------------------------------------------------------------------
// freq_div_ctrl_if
// Divisor-configuration channel of freq_div_ctrl: a valid/ready request that
// carries a new divisor, plus the error pulse returned for rejected values.
//
// Signals:
//   cfg_valid  master->slave  new-divisor request
//   cfg_div    master->slave  requested divisor (N bits)
//   cfg_ready  slave->master  1 while no divisor is pending
//   cfg_err    slave->master  one-cycle pulse after an out-of-range request
// With FREQ_DIV_DUTY_CFG_EN defined:
//   cfg_high   master->slave  requested high-phase length (N bits)
//   cur_high   slave->master  high-phase length currently in effect
// -----------------------------------------------------------------------------
interface freq_div_ctrl_if #(
  parameter int N = 26
);
  logic         cfg_valid;
  logic [N-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;
`ifdef FREQ_DIV_DUTY_CFG_EN
  logic [N-1:0] cfg_high;
  logic [N-1:0] cur_high;

  modport master (output cfg_valid, cfg_div, cfg_high,
                  input  cfg_ready, cfg_err, cur_high);
  modport slave  (input  cfg_valid, cfg_div, cfg_high,
                  output cfg_ready, cfg_err, cur_high);
`else
  modport master (output cfg_valid, cfg_div,
                  input  cfg_ready, cfg_err);
  modport slave  (input  cfg_valid, cfg_div,
                  output cfg_ready, cfg_err);
`endif
endinterface

// File: rtl/freq_div_ctrl.sv
// -----------------------------------------------------------------------------
// freq_div_ctrl
// Run-time programmable divide-by-M controller. A counter runs 0..M-1 while
// enabled; q is a square wave (low for floor(M/2) cycles, then high) and tick
// marks the last count of every period. New divisors arrive over a valid/ready
// channel, wait in a one-entry pending slot and only take effect at a period
// boundary (or immediately while idle), so no output period is ever truncated
// or stretched. Stopping is likewise deferred to the end of the period.
//
// Optional feature macro: FREQ_DIV_DUTY_CFG_EN
//   Adds a programmable high-phase length (cfg.cfg_high / cfg.cur_high) that
//   follows the same pending/apply rules as the divisor.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high; clears all state
//   i_enable   level: 1 = run, 0 = stop at the end of the current period
//   cfg        divisor configuration channel (slave side)
//   o_q        divided square wave (registered)
//   o_tick     one-cycle pulse on the last count of each period
//   o_running  1 while counting
//   o_cur_div  divisor currently in effect
// -----------------------------------------------------------------------------
module freq_div_ctrl #(
  parameter int N         = 26,
  parameter int DEFAULT_M = 50000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_enable,
  freq_div_ctrl_if.slave  cfg,
  output logic            o_q,
  output logic            o_tick,
  output logic            o_running,
  output logic [N-1:0]    o_cur_div
);

  localparam logic [N-1:0] DEF_DIV = N'(DEFAULT_M);
`ifdef FREQ_DIV_DUTY_CFG_EN
  localparam logic [N-1:0] DEF_HIGH = N'(DEFAULT_M - (DEFAULT_M / 2));
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t       r_state, w_state_nxt;
  logic [N-1:0] r_cnt, w_cnt_nxt;
  logic [N-1:0] r_div_q, w_div_nxt;
  logic [N-1:0] r_pend_div;
  logic         r_pend_valid;
  logic         r_q, w_q_nxt;
  logic         r_cfg_err;
  logic         w_wrap, w_accept, w_cfg_bad, w_apply;
`ifdef FREQ_DIV_DUTY_CFG_EN
  logic [N-1:0] r_high_q, w_high_nxt, r_pend_high;
`endif

  // Last count of a period: the only edge where state or divisor may change.
  assign w_wrap   = (r_state == RUN) && (r_cnt == r_div_q - N'(1));
  assign w_accept = cfg.cfg_valid && !r_pend_valid;
  // A pending divisor can only exist while cfg_ready is low, so acceptance
  // and application never coincide on one edge.
  assign w_apply  = r_pend_valid && ((r_state == IDLE) || w_wrap);

`ifdef FREQ_DIV_DUTY_CFG_EN
  assign w_cfg_bad  = (cfg.cfg_div < N'(2)) || (cfg.cfg_high == '0) ||
                      (cfg.cfg_high >= cfg.cfg_div);
  assign w_high_nxt = w_apply ? r_pend_high : r_high_q;
`else
  assign w_cfg_bad  = cfg.cfg_div < N'(2);
`endif
  assign w_div_nxt  = w_apply ? r_pend_div : r_div_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (i_enable) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_wrap) begin
          w_cnt_nxt = '0;
          if (!i_enable) w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + N'(1);
        end
      end
    endcase
  end

  // Output logic. q is computed from the next state/count/divisor and
  // registered, so it is glitch-free yet aligned with the current count.
  always_comb begin
    w_q_nxt   = 1'b0;
    o_tick    = w_wrap;
    o_running = (r_state == RUN);
    if (w_state_nxt == RUN) begin
`ifdef FREQ_DIV_DUTY_CFG_EN
      w_q_nxt = (w_cnt_nxt >= (w_div_nxt - w_high_nxt));
`else
      w_q_nxt = (w_cnt_nxt >= (w_div_nxt >> 1));
`endif
    end
  end

  // Divisor pipeline: pending slot, active divisor, error pulse and q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_q      <= DEF_DIV;
      r_pend_div   <= '0;
      r_pend_valid <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_q          <= 1'b0;
`ifdef FREQ_DIV_DUTY_CFG_EN
      r_high_q     <= DEF_HIGH;
      r_pend_high  <= '0;
`endif
    end else begin
      r_div_q   <= w_div_nxt;
      r_q       <= w_q_nxt;
      r_cfg_err <= w_accept && w_cfg_bad;
`ifdef FREQ_DIV_DUTY_CFG_EN
      r_high_q  <= w_high_nxt;
`endif
      if (w_apply) r_pend_valid <= 1'b0;
      // Rejected requests complete the handshake but leave the slot alone.
      if (w_accept && !w_cfg_bad) begin
        r_pend_valid <= 1'b1;
        r_pend_div   <= cfg.cfg_div;
`ifdef FREQ_DIV_DUTY_CFG_EN
        r_pend_high  <= cfg.cfg_high;
`endif
      end
    end
  end

  assign o_q           = r_q;
  assign o_cur_div     = r_div_q;
  assign cfg.cfg_ready = !r_pend_valid;
  assign cfg.cfg_err   = r_cfg_err;
`ifdef FREQ_DIV_DUTY_CFG_EN
  assign cfg.cur_high  = r_high_q;
`endif

endmodule

// File: tb/tb_freq_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freq_div_ctrl
// Self-checking bench for freq_div_ctrl with N=8, DEFAULT_M=10. Inputs are
// driven on the falling edge and outputs sampled on the falling edge, half a
// cycle away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_freq_div_ctrl;
  localparam int N  = 8;
  localparam int M0 = 10;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         en    = 1'b0;
  logic         q, tick, running;
  logic [N-1:0] cur_div;

  freq_div_ctrl_if #(.N(N)) cfg_if ();

  freq_div_ctrl #(.N(N), .DEFAULT_M(M0)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_enable  (en),
    .cfg       (cfg_if),
    .o_q       (q),
    .o_tick    (tick),
    .o_running (running),
    .o_cur_div (cur_div)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: position within the current output period, the period
  // length in force, and a one-deep queue of requested period lengths.
  // ---------------------------------------------------------------------------
  bit m_run, m_pend, m_err;
  int m_pos, m_div, m_pend_div;

  function automatic void model_reset();
    m_run = 0; m_pos = 0; m_div = M0; m_pend = 0; m_pend_div = 0; m_err = 0;
  endfunction

  function automatic void model_step(bit e, bit v, int d);
    bit last_of_period = m_run && (m_pos == m_div - 1);
    bit take           = v && !m_pend;
    bit switch_now     = m_pend && (!m_run || last_of_period);
    m_err = take && (d < 2);
    if (!m_run) begin
      m_run = e;
      m_pos = 0;
    end else if (last_of_period) begin
      m_pos = 0;
      m_run = e;
    end else begin
      m_pos = m_pos + 1;
    end
    if (switch_now) begin
      m_div  = m_pend_div;
      m_pend = 0;
    end
    if (take && d >= 2) begin
      m_pend     = 1;
      m_pend_div = d;
    end
  endfunction

  task automatic compare_all(string tag);
    check({tag, " q"},       int'(q),         int'(m_run && (m_pos >= m_div / 2)));
    check({tag, " tick"},    int'(tick),      int'(m_run && (m_pos == m_div - 1)));
    check({tag, " running"}, int'(running),   int'(m_run));
    check({tag, " ready"},   int'(cfg_if.cfg_ready), int'(!m_pend));
    check({tag, " err"},     int'(cfg_if.cfg_err),   int'(m_err));
    check({tag, " cur_div"}, int'(cur_div),   m_div);
  endtask

  // Tick-to-tick interval log (measured on the DUT's tick).
  int cyc = 0, last_tick = 0;
  bit have_last = 0;
  int periods[$];

  function automatic void reset_periods();
    have_last = 0;
    periods.delete();
  endfunction

  task automatic drive(bit e, bit v, int d);
    en               = e;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_div   = N'(d);
`ifdef FREQ_DIV_DUTY_CFG_EN
    cfg_if.cfg_high  = N'(d - d / 2);
`endif
  endtask

  // One clock cycle: drive at negedge, model steps at posedge, compare at
  // the following negedge.
  task automatic cycle(bit e, bit v, int d);
    drive(e, v, d);
    @(posedge clk);
    model_step(e, v, d);
    @(negedge clk);
    compare_all($sformatf("cyc%0d", cyc));
    if (tick) begin
      if (have_last) periods.push_back(cyc - last_tick);
      last_tick = cyc;
      have_last = 1;
    end
    cyc++;
  endtask

  task automatic run_to_pos(int target, bit e);
    bit hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      cycle(e, 1'b0, 0);
      hit = m_run && (m_pos == target);
    end
    check($sformatf("reach cnt=%0d", target), int'(hit), 1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_periods(string tag, int p0, int p1, int p2);
    check({tag, " period count"}, int'(periods.size() >= 3), 1);
    if (periods.size() >= 3) begin
      check({tag, " period0"}, periods[0], p0);
      check({tag, " period1"}, periods[1], p1);
      check({tag, " period2"}, periods[2], p2);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: start, free-run, then stop requested at cnt=3.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit en;
    bit q;
    bit tick;
    bit run;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vv;
    // Rows 0..13: enable held, count i%10 after each edge.
    for (int i = 0; i < 14; i++) begin
      vv.en = 1; vv.run = 1;
      vv.q = ((i % 10) >= 5); vv.tick = ((i % 10) == 9);
      vecs.push_back(vv);
    end
    // Rows 14..19: enable dropped after cnt=3, period still completes.
    for (int i = 14; i < 20; i++) begin
      vv.en = 0; vv.run = 1;
      vv.q = ((i - 10) >= 5); vv.tick = ((i - 10) == 9);
      vecs.push_back(vv);
    end
    // Rows 20..22: back in IDLE.
    for (int i = 20; i < 23; i++) begin
      vv.en = 0; vv.run = 0; vv.q = 0; vv.tick = 0;
      vecs.push_back(vv);
    end

    // Reset state.
    apply_reset();
    check("reset q",       int'(q), 0);
    check("reset tick",    int'(tick), 0);
    check("reset running", int'(running), 0);
    check("reset ready",   int'(cfg_if.cfg_ready), 1);
    check("reset err",     int'(cfg_if.cfg_err), 0);
    check("reset cur_div", int'(cur_div), M0);

    foreach (vecs[i]) begin
      drive(vecs[i].en, 1'b0, 0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d q", i),       int'(q),       int'(vecs[i].q));
      check($sformatf("vec%0d tick", i),    int'(tick),    int'(vecs[i].tick));
      check($sformatf("vec%0d running", i), int'(running), int'(vecs[i].run));
      check($sformatf("vec%0d ready", i),   int'(cfg_if.cfg_ready), 1);
      check($sformatf("vec%0d cur_div", i), int'(cur_div), M0);
    end

    // Divisor 6 accepted mid-period: current period stays 10.
    apply_reset();
    reset_periods();
    run_to_pos(9, 1'b1);
    run_to_pos(2, 1'b1);
    cycle(1'b1, 1'b1, 6);
    check("div6 ready after accept", int'(cfg_if.cfg_ready), 0);
    check("div6 cur_div before wrap", int'(cur_div), M0);
    run_to_pos(9, 1'b1);
    check("div6 ready at cnt9", int'(cfg_if.cfg_ready), 0);
    cycle(1'b1, 1'b0, 0);
    check("div6 cur_div after wrap", int'(cur_div), 6);
    check("div6 ready after wrap", int'(cfg_if.cfg_ready), 1);
    repeat (12) cycle(1'b1, 1'b0, 0);
    check_periods("div6", 10, 6, 6);

    // Divisor 4 accepted on the wrap edge: applies one period later.
    apply_reset();
    reset_periods();
    run_to_pos(9, 1'b1);
    cycle(1'b1, 1'b1, 4);
    check("div4 ready after accept", int'(cfg_if.cfg_ready), 0);
    check("div4 cur_div unchanged", int'(cur_div), M0);
    repeat (20) cycle(1'b1, 1'b0, 0);
    check_periods("div4", 10, 4, 4);

    // Out-of-range divisors 1 then 0.
    apply_reset();
    run_to_pos(4, 1'b1);
    cycle(1'b1, 1'b1, 1);
    check("bad1 err pulse", int'(cfg_if.cfg_err), 1);
    check("bad1 ready", int'(cfg_if.cfg_ready), 1);
    cycle(1'b1, 1'b0, 0);
    check("bad1 err clears", int'(cfg_if.cfg_err), 0);
    cycle(1'b1, 1'b1, 0);
    check("bad0 err pulse", int'(cfg_if.cfg_err), 1);
    cycle(1'b1, 1'b0, 0);
    check("bad0 err clears", int'(cfg_if.cfg_err), 0);
    check("bad cur_div", int'(cur_div), M0);
    reset_periods();
    repeat (35) cycle(1'b1, 1'b0, 0);
    check_periods("bad", 10, 10, 10);

    // Asynchronous reset while q=1 at cnt=7 with a divisor pending.
    apply_reset();
    run_to_pos(2, 1'b1);
    cycle(1'b1, 1'b1, 6);
    run_to_pos(7, 1'b1);
    check("arst q before", int'(q), 1);
    check("arst pending before", int'(cfg_if.cfg_ready), 0);
    #2 reset = 1'b1;
    #1;
    check("arst q",       int'(q), 0);
    check("arst tick",    int'(tick), 0);
    check("arst running", int'(running), 0);
    check("arst ready",   int'(cfg_if.cfg_ready), 1);
    check("arst err",     int'(cfg_if.cfg_err), 0);
    check("arst cur_div", int'(cur_div), M0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    reset_periods();
    repeat (45) cycle(1'b1, 1'b0, 0);
    check_periods("arst", 10, 10, 10);
    check("arst cur_div after", int'(cur_div), M0);

    // Randomised traffic against the model.
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
            int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/freq_div_ctrl.md
Name: freq_div_ctrl

Overview:
- Run-time programmable frequency-divider controller. It sequences a divide-by-M counter: start and stop, glitch-free divisor reconfiguration through a valid/ready handshake, a square-wave output and a one-cycle period tick.
- Sits between the system clock domain and low-rate consumers (LED blinkers, 1 Hz timebases, scan clocks). The control plane loads new divisors without ever producing a truncated or stretched output period.

Parameters:
- N, 26: counter and divisor width in bits.
- DEFAULT_M, 50000000: divisor loaded at reset. Legal range is 2 to 2^N-1.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  level; 1 requests running, 0 requests stop.
- cfg_valid  in  1  new-divisor request.
- cfg_div  in  N  requested divisor, sampled when cfg_valid && cfg_ready.
- cfg_ready  out  1  1 when no divisor is pending.
- cfg_err  out  1  one-cycle pulse when an accepted cfg_div is < 2.
- q  out  1  divided square wave.
- tick  out  1  one-cycle pulse on the last count of each period.
- running  out  1  1 while in state RUN.
- cur_div  out  N  divisor currently in effect.

Behaviour:
- Reset values:
  - state = IDLE, cnt = 0, div_q = DEFAULT_M, pend_valid = 0, pend_div = 0.
  - q = 0, tick = 0, running = 0, cfg_ready = 1, cfg_err = 0, cur_div = DEFAULT_M.
- States:
  - IDLE: cnt held at 0, q = 0, tick = 0.
  - RUN: cnt counts 0..div_q-1 and wraps to 0.
- IDLE -> RUN: on an edge with enable = 1. cnt = 0 in the first RUN cycle.
- RUN -> IDLE: only at the wrap edge (cnt == div_q-1) with enable = 0. The current period always completes, so no truncated high or low phase occurs.
- Registered outputs:
  - q = 1 iff state == RUN and cnt >= div_q>>1.
  - Low phase is floor(M/2) cycles; high phase is M - floor(M/2) cycles.
- tick:
  - Combinational: state == RUN && cnt == div_q-1.
  - Exactly one pulse per period, coincident with the last high cycle of q.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready at a clock edge.
  - cfg_ready = !pend_valid.
  - cfg_valid may be held; it is sampled only when ready.
- Invalid divisor (cfg_div < 2):
  - The transfer completes but the value is discarded.
  - cfg_err pulses high for exactly 1 cycle after the edge.
  - pend_valid is unchanged.
- Valid divisor: pend_div <= cfg_div, pend_valid <= 1.
- Applying a pending divisor:
  - In IDLE: div_q <= pend_div on the next edge and pend_valid <= 0. This happens one cycle after acceptance.
  - In RUN: applied only at a wrap edge, so the next period uses the new divisor.
- Same-edge accept + wrap: pend_valid was 0 before that edge, so nothing applies at this wrap. The new divisor applies at the following wrap.
- Disable and pending divisor on the same wrap edge: state -> IDLE and div_q <= pend_div on that same edge.
- Counter width: cnt is N bits and never exceeds div_q-1. Comparisons are unsigned and there is no overflow path.
- Asynchronous reset mid-period:
  - Every output goes to its reset value immediately.
  - Any pending divisor is lost.
  - div_q returns to DEFAULT_M.

Optional Feature:
- Macro: FREQ_DIV_DUTY_CFG_EN.
- Defined:
  - Adds input cfg_high [N-1:0], sampled alongside cfg_div, and output cur_high [N-1:0].
  - Pending and apply rules for cfg_high are identical to cfg_div.
  - q = 1 iff cnt >= div_q - high_q, i.e. the high phase lasts high_q cycles.
  - Reset high_q = DEFAULT_M - (DEFAULT_M>>1).
  - cfg_high == 0 or cfg_high >= cfg_div counts as invalid: cfg_err pulses and both values are discarded.
- Undefined: ports absent; the duty cycle is fixed by the div_q>>1 rule.

Test Plan (bench uses N=8, DEFAULT_M=10):
- Reset, then enable=1 held -> q is 0 for 5 cycles and 1 for 5 cycles, repeating. tick pulses every 10 cycles, on cycle 9 of each period. running=1 from the cycle after enable is sampled.
- Drop enable at cnt=3 -> q, tick and the count continue until cnt=9. State is IDLE at the next edge, q=0 and running=0. No period shorter than 10 cycles.
- While running, cfg_div=6 accepted at cnt=2 -> cfg_ready=0 until the wrap. The current period stays 10 cycles. The next periods are 6 cycles (q 3 low / 3 high). cur_div=6 after the wrap. cfg_ready returns to 1.
- cfg_div=4 accepted on the same edge as cnt=9 -> the next period is still 10 cycles. The period after it is 4 cycles.
- cfg_div=1 and then cfg_div=0 -> cfg_err gives two 1-cycle pulses. cur_div, period and cfg_ready are unaffected.
- Assert reset while q=1 at cnt=7 with a pending divisor -> all outputs go to reset values immediately. After reset is released, enable=1 gives 10-cycle periods and the pending divisor is never applied.
